// File: rtl/cache_refill_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cache_refill_ctrl_pkg
//  Purpose  : Shared types, sizes and address-field helpers for the
//             2-way instruction cache refill controller.
//  Revision : 1.0 - initial release
// ============================================================================
package cache_refill_ctrl_pkg;

  localparam int NUM_LINES  = 8;
  localparam int BEAT_W     = 32;
  localparam int LINE_BEATS = 8;
  localparam int LINE_W     = LINE_BEATS * BEAT_W;  // 256
  localparam int TAG_W      = 24;
  localparam int IDX_W      = $clog2(NUM_LINES);
  localparam int CNT_W      = $clog2(LINE_BEATS);

  // Address field slices of a fetch PC
  localparam int OFFSET_HI = 4;
  localparam int OFFSET_LO = 0;
  localparam int INDEX_HI  = 7;
  localparam int INDEX_LO  = 5;
  localparam int HTAG_HI   = 11;
  localparam int HTAG_LO   = 8;
  localparam int MTAG_HI   = 31;
  localparam int MTAG_LO   = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FILL  = 2'd2,
    WRITE = 2'd3
  } state_t;

  function automatic logic [IDX_W-1:0] addr_index(input logic [31:0] a);
    return a[INDEX_HI:INDEX_LO];
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] a);
    return {a[MTAG_HI:MTAG_LO], a[HTAG_HI:HTAG_LO]};
  endfunction

  // Clears the byte-offset field so the request is line aligned
  function automatic logic [31:0] line_base(input logic [31:0] a);
    return a & ~((32'd1 << (OFFSET_HI - OFFSET_LO + 1)) - 32'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_refill_ctrl_lru_table.sv
`default_nettype none
// ============================================================================
//  Module   : cache_refill_ctrl_lru_table
//  Purpose  : One replacement bit per index (value = way to evict next).
//             Two write ports: lookup hit and line fill; fill wins on a
//             same-index collision. One combinational read port.
//  Revision : 1.0 - initial release
// ============================================================================
module cache_refill_ctrl_lru_table
  import cache_refill_ctrl_pkg::*;
#(
  parameter int LINES = NUM_LINES
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     hit_we,
  input  logic [$clog2(LINES)-1:0] hit_index,
  input  logic                     hit_way,
  input  logic                     fill_we,
  input  logic [$clog2(LINES)-1:0] fill_index,
  input  logic                     fill_way,
  input  logic [$clog2(LINES)-1:0] rd_index,
  output logic                     rd_way
);

  logic [LINES-1:0] lru;

  // Point each touched index at the other way; the fill write comes last so it overrides a hit on the same index
  always_ff @(posedge clk) begin
    if (!reset) begin
      lru <= '0;
    end else begin
      if (hit_we) lru[hit_index] <= ~hit_way;
      if (fill_we) lru[fill_index] <= ~fill_way;
    end
  end

  assign rd_way = lru[rd_index];

endmodule
`default_nettype wire

// File: rtl/cache_refill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cache_refill_ctrl
//  Purpose  : Refill engine for the 2-way instruction cache. Accepts a miss,
//             requests the 32B line, assembles 8 x 32-bit beats and writes
//             data/tag/valid into the LRU victim way.
//  Revision : 1.0 - initial release
// ============================================================================
module cache_refill_ctrl
  import cache_refill_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              miss_valid,
  input  logic [31:0]       miss_addr,
  output logic              miss_ready,
  input  logic              acc_valid,
  input  logic [IDX_W-1:0]  acc_index,
  input  logic              acc_way,
  output logic              mem_req,
  output logic [31:0]       mem_addr,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [BEAT_W-1:0] mem_rdata,
  output logic              regWrite_set0,
  output logic              regWrite_set1,
  output logic [IDX_W-1:0]  wr_index,
  output logic [TAG_W-1:0]  in_tag,
  output logic              inp_viv,
  output logic [LINE_W-1:0] inputData,
  output logic              fill_done
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_BEATS - 1);

  state_t           state;
  logic [CNT_W-1:0] beat_cnt;
  logic             victim;
  logic             lru_way;

  // fill_done is high exactly during the WRITE cycle, so it doubles as the fill-port enable
  cache_refill_ctrl_lru_table #(
    .LINES (NUM_LINES)
  ) u_lru_table (
    .clk        (clk),
    .reset      (reset),
    .hit_we     (acc_valid),
    .hit_index  (acc_index),
    .hit_way    (acc_way),
    .fill_we    (fill_done),
    .fill_index (wr_index),
    .fill_way   (victim),
    .rd_index   (addr_index(miss_addr)),
    .rd_way     (lru_way)
  );

  // Refill FSM with registered handshake/strobe outputs, beat counter and line assembly
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      beat_cnt      <= '0;
      victim        <= 1'b0;
      mem_addr      <= '0;
      in_tag        <= '0;
      wr_index      <= '0;
      inputData     <= '0;
      miss_ready    <= 1'b1;
      mem_req       <= 1'b0;
      regWrite_set0 <= 1'b0;
      regWrite_set1 <= 1'b0;
      inp_viv       <= 1'b0;
      fill_done     <= 1'b0;
    end else begin
      regWrite_set0 <= 1'b0;
      regWrite_set1 <= 1'b0;
      inp_viv       <= 1'b0;
      fill_done     <= 1'b0;
      case (state)
        IDLE: begin
          if (miss_valid) begin
            mem_addr   <= line_base(miss_addr);
            in_tag     <= addr_tag(miss_addr);
            wr_index   <= addr_index(miss_addr);
            victim     <= lru_way;
            beat_cnt   <= '0;
            miss_ready <= 1'b0;
            mem_req    <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= FILL;
          end
        end
        FILL: begin
          if (mem_rvalid) begin
            inputData[32'(beat_cnt) * BEAT_W +: BEAT_W] <= mem_rdata;
            beat_cnt <= beat_cnt + CNT_W'(1);
            if (beat_cnt == LAST_BEAT) begin
              regWrite_set0 <= ~victim;
              regWrite_set1 <= victim;
              inp_viv       <= 1'b1;
              fill_done     <= 1'b1;
              state         <= WRITE;
            end
          end
        end
        WRITE: begin
          miss_ready <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_refill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cache_refill_ctrl
//  Purpose  : Directed self-checking bench for cache_refill_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cache_refill_ctrl;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         miss_valid = 1'b0;
  logic [31:0]  miss_addr = '0;
  logic         miss_ready;
  logic         acc_valid = 1'b0;
  logic [2:0]   acc_index = '0;
  logic         acc_way = 1'b0;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ack = 1'b0;
  logic         mem_rvalid = 1'b0;
  logic [31:0]  mem_rdata = '0;
  logic         regWrite_set0;
  logic         regWrite_set1;
  logic [2:0]   wr_index;
  logic [23:0]  in_tag;
  logic         inp_viv;
  logic [255:0] inputData;
  logic         fill_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cache_refill_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .miss_valid    (miss_valid),
    .miss_addr     (miss_addr),
    .miss_ready    (miss_ready),
    .acc_valid     (acc_valid),
    .acc_index     (acc_index),
    .acc_way       (acc_way),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .regWrite_set0 (regWrite_set0),
    .regWrite_set1 (regWrite_set1),
    .wr_index      (wr_index),
    .in_tag        (in_tag),
    .inp_viv       (inp_viv),
    .inputData     (inputData),
    .fill_done     (fill_done)
  );

  // One complete refill; inputs change and outputs are sampled on negedge
  task automatic run_fill(input string name, input logic [31:0] a, input logic [31:0] seed,
                          input int ack_wait, input int gap, input logic rv_in_req,
                          input logic exp_way, input logic hit_en, input logic [2:0] hit_idx,
                          input logic hit_way, input logic hold_next, input logic [31:0] next_addr);
    logic [255:0] exp_line;
    logic [31:0]  beat;
    int n;
    exp_line = '0;
    n = 0;
    while (!miss_ready && n < 200) begin @(negedge clk); n++; end
    n_checks++;
    if (miss_ready !== 1'b1) begin n_fail++; $display("FAIL %s.ready_wait: miss_ready=%b required 1", name, miss_ready); end
    miss_valid = 1'b1;
    miss_addr  = a;
    @(negedge clk);
    miss_valid = 1'b0;
    n_checks++;
    if (mem_req !== 1'b1) begin n_fail++; $display("FAIL %s.mem_req: got %b required 1", name, mem_req); end
    n_checks++;
    if (mem_addr !== {a[31:5], 5'b0}) begin n_fail++; $display("FAIL %s.mem_addr: got %h required %h", name, mem_addr, {a[31:5], 5'b0}); end
    n_checks++;
    if (miss_ready !== 1'b0) begin n_fail++; $display("FAIL %s.busy: miss_ready=%b required 0", name, miss_ready); end
    repeat (ack_wait) begin
      mem_rvalid = rv_in_req;
      mem_rdata  = 32'hDEAD_BEEF;
      @(negedge clk);
    end
    mem_ack    = 1'b1;
    mem_rvalid = rv_in_req;
    mem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_ack    = 1'b0;
    mem_rvalid = 1'b0;
    n_checks++;
    if (mem_req !== 1'b0) begin n_fail++; $display("FAIL %s.req_drop: mem_req=%b required 0", name, mem_req); end
    if (hold_next) begin
      miss_valid = 1'b1;
      miss_addr  = next_addr;
    end
    for (int k = 0; k < 8; k++) begin
      repeat (gap) @(negedge clk);
      n_checks++;
      if ((regWrite_set0 | regWrite_set1) !== 1'b0) begin
        n_fail++; $display("FAIL %s.early_write beat %0d: strobes=%b%b required 00", name, k, regWrite_set1, regWrite_set0);
      end
      beat = seed * 32'(k + 1);
      exp_line[k*32 +: 32] = beat;
      mem_rvalid = 1'b1;
      mem_rdata  = beat;
      @(negedge clk);
      mem_rvalid = 1'b0;
    end
    // WRITE cycle
    if (hit_en) begin
      acc_valid = 1'b1;
      acc_index = hit_idx;
      acc_way   = hit_way;
    end
    n_checks++;
    if (regWrite_set0 !== ~exp_way) begin n_fail++; $display("FAIL %s.set0: got %b required %b", name, regWrite_set0, ~exp_way); end
    n_checks++;
    if (regWrite_set1 !== exp_way) begin n_fail++; $display("FAIL %s.set1: got %b required %b", name, regWrite_set1, exp_way); end
    n_checks++;
    if ({fill_done, inp_viv} !== 2'b11) begin n_fail++; $display("FAIL %s.done_viv: got %b%b required 11", name, fill_done, inp_viv); end
    n_checks++;
    if (in_tag !== a[31:8]) begin n_fail++; $display("FAIL %s.in_tag: got %h required %h", name, in_tag, a[31:8]); end
    n_checks++;
    if (wr_index !== a[7:5]) begin n_fail++; $display("FAIL %s.wr_index: got %0d required %0d", name, wr_index, a[7:5]); end
    n_checks++;
    if (inputData !== exp_line) begin n_fail++; $display("FAIL %s.line: got %h required %h", name, inputData, exp_line); end
    n_checks++;
    if (miss_ready !== 1'b0) begin n_fail++; $display("FAIL %s.ready_in_write: got %b required 0", name, miss_ready); end
    @(negedge clk);
    acc_valid = 1'b0;
    n_checks++;
    if ({regWrite_set1, regWrite_set0, fill_done, inp_viv} !== 4'b0000) begin
      n_fail++; $display("FAIL %s.strobe_width: got %b%b%b%b required 0000", name, regWrite_set1, regWrite_set0, fill_done, inp_viv);
    end
    n_checks++;
    if (miss_ready !== 1'b1) begin n_fail++; $display("FAIL %s.ready_after: got %b required 1", name, miss_ready); end
    n_checks++;
    if (inputData !== exp_line) begin n_fail++; $display("FAIL %s.line_hold: got %h required %h", name, inputData, exp_line); end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({mem_req, regWrite_set0, regWrite_set1, inp_viv, fill_done} !== 5'b0) begin
      n_fail++; $display("FAIL reset.strobes: got %b%b%b%b%b required 00000", mem_req, regWrite_set0, regWrite_set1, inp_viv, fill_done);
    end
    n_checks++;
    if ({inputData, in_tag, wr_index} !== '0) begin n_fail++; $display("FAIL reset.data: line=%h tag=%h idx=%0d required 0", inputData, in_tag, wr_index); end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (miss_ready !== 1'b1) begin n_fail++; $display("FAIL reset.miss_ready: got %b required 1", miss_ready); end
  endtask

  task automatic test_first_and_second_miss();
    run_fill("first_miss",  32'h0000_1A40, 32'h1111_1111, 1, 0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
    run_fill("second_miss", 32'h0000_2A40, 32'h0102_0304, 0, 0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_hit_then_miss();
    // lru[2]=0 after the second fill; a hit on way 0 flips it to 1
    acc_valid = 1'b1; acc_index = 3'd2; acc_way = 1'b0;
    @(negedge clk);
    acc_valid = 1'b0;
    run_fill("hit_then_miss", 32'h0000_3A40, 32'h2000_0001, 0, 0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_hit_fill_collision();
    // Fill idx 5 (victim 0) with a way-1 hit on idx 5 in the WRITE cycle: fill leaves lru[5]=1
    run_fill("collide_fill", 32'h0000_00A0, 32'h0300_0003, 0, 0, 1'b0, 1'b0, 1'b1, 3'd5, 1'b1, 1'b0, 32'h0);
    run_fill("collide_next", 32'h0000_10A0, 32'h0400_0004, 0, 0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
    // Fill idx 4 (victim 0) with a way-0 hit on idx 6: lru[4]=1 and lru[6]=1
    run_fill("split_fill",   32'h0000_0080, 32'h0500_0005, 0, 0, 1'b0, 1'b0, 1'b1, 3'd6, 1'b0, 1'b0, 32'h0);
    run_fill("split_idx6",   32'h0000_00C0, 32'h0600_0006, 0, 0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
    run_fill("split_idx4",   32'h0000_1080, 32'h0700_0007, 0, 0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_gaps_and_held_miss();
    run_fill("gapped",     32'h0000_0020, 32'h0800_0008, 2, 3, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 32'h0000_5040);
    run_fill("held_miss",  32'h0000_5040, 32'h0900_0009, 0, 0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_reset_mid_fill();
    miss_valid = 1'b1; miss_addr = 32'h0000_0060;
    @(negedge clk);
    miss_valid = 1'b0;
    n_checks++;
    if (mem_addr !== 32'h0000_0060) begin n_fail++; $display("FAIL abort.mem_addr: got %h required 00000060", mem_addr); end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    for (int k = 0; k < 5; k++) begin
      mem_rvalid = 1'b1; mem_rdata = 32'h0F0F_0F0F + 32'(k);
      @(negedge clk);
    end
    mem_rvalid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    n_checks++;
    if ({mem_req, regWrite_set0, regWrite_set1, inp_viv, fill_done, miss_ready} !== 6'b000001) begin
      n_fail++; $display("FAIL abort.ctrl: req/s0/s1/viv/done/ready=%b%b%b%b%b%b required 000001",
                         mem_req, regWrite_set0, regWrite_set1, inp_viv, fill_done, miss_ready);
    end
    n_checks++;
    if ({inputData, in_tag, wr_index} !== '0) begin n_fail++; $display("FAIL abort.data: line=%h tag=%h idx=%0d required 0", inputData, in_tag, wr_index); end
    for (int k = 5; k < 8; k++) begin
      mem_rvalid = 1'b1; mem_rdata = 32'h0F0F_0F0F + 32'(k);
      @(negedge clk);
      mem_rvalid = 1'b0;
      n_checks++;
      if ({regWrite_set0, regWrite_set1, miss_ready, mem_req} !== 4'b0010) begin
        n_fail++; $display("FAIL abort.stray_beat %0d: s0/s1/ready/req=%b%b%b%b required 0010", k, regWrite_set0, regWrite_set1, miss_ready, mem_req);
      end
    end
    // LRU was cleared: idx 2 replaces way 0 again, and the line starts from beat 0
    run_fill("after_abort", 32'h0000_1A40, 32'h1357_9BDF, 0, 0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_first_and_second_miss();
    test_hit_then_miss();
    test_hit_fill_collision();
    test_gaps_and_held_miss();
    test_reset_mid_fill();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
